// File: rtl/pr_tape_frame_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pr_tape_frame_buf: photo-reader frame FIFO feeding the M19/M23 insertion |
// | path with per-word digit bits and strobes. Option: G15_RDR_PARITY_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pr_tape_frame_buf #(
  parameter int DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T0,
  input  logic       IN,
  input  logic       PREC1,
`ifdef G15_RDR_PARITY_EN
  input  logic [5:0] host_data,
`else
  input  logic [4:0] host_data,
`endif
  input  logic       host_valid,
  output logic       host_ready,
  output logic       OA1,
  output logic       OA2,
  output logic       OA3,
  output logic       OA4,
  output logic       DIGIT_OF,
  output logic       CR_TAB_OF,
  output logic       WAIT_OF,
  output logic       STOP_OF,
  output logic       RELOAD_OF,
  output logic       MINUS_OF,
  output logic       RDR_HALT,
  output logic       PARITY_ERR
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRES4, S_PRES1, S_CTRL} state_t;

  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_push, w_pop, w_frame_ok;
  logic [4:0]    w_head;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_oa, w_oa_nx;
  logic [3:0]    r_digit, w_digit_nx;
  logic [1:0]    r_bit_idx, w_bit_nx;
  logic [5:0]    r_strb, w_strb_nx;   // {DIGIT, CR_TAB, WAIT, STOP, RELOAD, MINUS}
  logic          r_halt, w_halt_nx;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign host_ready = ~w_full;
  assign w_head     = r_mem[r_rd_ptr];

`ifdef G15_RDR_PARITY_EN
  logic r_parity_err;
  assign w_frame_ok = ^host_data;
  assign PARITY_ERR = r_parity_err;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)
      r_parity_err <= 1'b0;
    else if (host_valid && host_ready && !w_frame_ok)
      r_parity_err <= 1'b1;
  end
`else
  assign w_frame_ok = 1'b1;
  assign PARITY_ERR = 1'b0;
`endif

  // A bad-parity frame completes the handshake but never reaches the FIFO.
  assign w_push = host_valid & host_ready & w_frame_ok;

  always_ff @(posedge CLOCK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= host_data[4:0];
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_oa      <= '0;
      r_digit   <= '0;
      r_bit_idx <= '0;
      r_strb    <= '0;
      r_halt    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_oa      <= w_oa_nx;
      r_digit   <= w_digit_nx;
      r_bit_idx <= w_bit_nx;
      r_strb    <= w_strb_nx;
      r_halt    <= w_halt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_oa_nx    = r_oa;
    w_digit_nx = r_digit;
    w_bit_nx   = r_bit_idx;
    w_strb_nx  = r_strb;
    w_halt_nx  = r_halt & IN;
    w_pop      = 1'b0;
    if (T0) begin
      if (!IN) begin
        w_state_nx = S_IDLE;
        w_oa_nx    = '0;
        w_strb_nx  = '0;
      end else if (r_state == S_PRES1 && r_bit_idx != 2'd0) begin
        w_bit_nx = r_bit_idx - 2'd1;
        w_oa_nx  = {3'b000, r_digit[w_bit_nx]};
      end else begin
        // End of any presentation word falls straight into a fresh pop.
        w_state_nx = S_IDLE;
        w_oa_nx    = '0;
        w_strb_nx  = '0;
        if (!r_halt && !w_empty) begin
          w_pop = 1'b1;
          if (w_head[4]) begin
            w_digit_nx   = w_head[3:0];
            w_strb_nx[5] = 1'b1;
            if (PREC1) begin
              w_state_nx = S_PRES1;
              w_bit_nx   = 2'd3;
              w_oa_nx    = {3'b000, w_head[3]};
            end else begin
              w_state_nx = S_PRES4;
              w_oa_nx    = w_head[3:0];
            end
          end else begin
            case (w_head[3:0])
              4'h1: begin w_strb_nx[0] = 1'b1; w_state_nx = S_CTRL; end
              4'h2,
              4'h3: begin w_strb_nx[4] = 1'b1; w_state_nx = S_CTRL; end
              4'h4: begin w_strb_nx[2] = 1'b1; w_state_nx = S_CTRL; w_halt_nx = 1'b1; end
              4'h5: begin w_strb_nx[1] = 1'b1; w_state_nx = S_CTRL; end
              4'h7: begin w_strb_nx[3] = 1'b1; w_state_nx = S_CTRL; end
              default: w_state_nx = S_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign OA1       = r_oa[0];
  assign OA2       = r_oa[1];
  assign OA3       = r_oa[2];
  assign OA4       = r_oa[3];
  assign DIGIT_OF  = r_strb[5];
  assign CR_TAB_OF = r_strb[4];
  assign STOP_OF   = r_strb[2];
  assign WAIT_OF   = r_strb[3];
  assign RELOAD_OF = r_strb[1];
  assign MINUS_OF  = r_strb[0];
  assign RDR_HALT  = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_pr_tape_frame_buf.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for pr_tape_frame_buf: expected presentation words are
// queued with the stimulus and matched in order by a per-word monitor.
module tb_pr_tape_frame_buf;

  logic CLOCK = 1'b0;
  logic rst, T0, IN, PREC1, host_valid, host_ready;
`ifdef G15_RDR_PARITY_EN
  logic [5:0] host_data;
`else
  logic [4:0] host_data;
`endif
  logic OA1, OA2, OA3, OA4;
  logic DIGIT_OF, CR_TAB_OF, WAIT_OF, STOP_OF, RELOAD_OF, MINUS_OF;
  logic RDR_HALT, PARITY_ERR;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  pr_tape_frame_buf #(.DEPTH(4)) dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .IN(IN), .PREC1(PREC1),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .OA1(OA1), .OA2(OA2), .OA3(OA3), .OA4(OA4),
    .DIGIT_OF(DIGIT_OF), .CR_TAB_OF(CR_TAB_OF), .WAIT_OF(WAIT_OF),
    .STOP_OF(STOP_OF), .RELOAD_OF(RELOAD_OF), .MINUS_OF(MINUS_OF),
    .RDR_HALT(RDR_HALT), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  // Word = 8 bit times; T0 high for the last bit time of each word.
  initial begin
    T0 = 1'b0;
    forever begin
      repeat (7) @(negedge CLOCK);
      T0 = 1'b1;
      @(negedge CLOCK);
      T0 = 1'b0;
    end
  end

  function automatic logic [9:0] out_vec();
    return {DIGIT_OF, CR_TAB_OF, WAIT_OF, STOP_OF, RELOAD_OF, MINUS_OF,
            OA4, OA3, OA2, OA1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every non-idle presentation word must match the queue head.
  initial begin
    logic [9:0] v;
    forever begin
      @(posedge CLOCK);
      if (T0 === 1'b1 && rst === 1'b0) begin
        #1;
        v = out_vec();
        if (v != 10'h000) begin
          if (exp_q.size() == 0) check("unexpected_word", 32'(v), 32'h0);
          else                   check("word", 32'(v), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_t0();
    do @(posedge CLOCK); while (T0 !== 1'b1);
  endtask

  task automatic push(input logic [4:0] f);
    int n = 0;
    @(negedge CLOCK);
`ifdef G15_RDR_PARITY_EN
    host_data = {~^f, f};
`else
    host_data = f;
`endif
    host_valid = 1'b1;
    while (!host_ready && n < 300) begin
      @(negedge CLOCK);
      n++;
    end
    if (!host_ready) check("push_timeout", 32'(host_ready), 32'h1);
    @(negedge CLOCK);
    host_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      wait_t0();
      n++;
    end
    repeat (3) wait_t0();
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] tbl_f [6];
    logic [9:0] tbl_e [6];
    rst = 1'b1; IN = 1'b0; PREC1 = 1'b0; host_valid = 1'b0; host_data = '0;
    repeat (3) @(negedge CLOCK);
    check("reset_outputs", 32'(out_vec()), 32'h0);
    check("reset_ready", 32'(host_ready), 32'h1);
    check("reset_halt", 32'(RDR_HALT), 32'h0);
    check("reset_parity", 32'(PARITY_ERR), 32'h0);
    rst = 1'b0;

    // 4-bit digit 0xA
    IN = 1'b1;
    exp_q.push_back(10'h20A);
    push(5'h1A);
    drain("t1_digit4_drain");
    check("t1_ready", 32'(host_ready), 32'h1);

    // 1-bit precision digit 0x5: OA1 = 0,1,0,1
    PREC1 = 1'b1;
    exp_q.push_back(10'h200); exp_q.push_back(10'h201);
    exp_q.push_back(10'h200); exp_q.push_back(10'h201);
    push(5'h15);
    drain("t2_digit1_drain");
    PREC1 = 1'b0;

    // FIFO fill with IN low, fifth frame held until first pop
    @(negedge CLOCK); IN = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(10'h200 | 10'(i));
    for (int i = 1; i <= 4; i++) push(5'h10 | 5'(i));
    check("t3_full_ready", 32'(host_ready), 32'h0);
    check("t3_no_output", 32'(exp_q.size()), 32'h5);
    fork
      push(5'h15);
      begin repeat (2) @(negedge CLOCK); IN = 1'b1; end
    join
    drain("t3_order_drain");

    // Stop code halts reader; queued digit waits for IN pulse
    exp_q.push_back(10'h040);
    push(5'h04);
    push(5'h13);
    drain("t4_stop_drain");
    check("t4_halt_set", 32'(RDR_HALT), 32'h1);
    check("t4_ready_held", 32'(host_ready), 32'h1);
    exp_q.push_back(10'h203);
    @(negedge CLOCK); IN = 1'b0;
    wait_t0();
    @(negedge CLOCK);
    check("t4_halt_clear", 32'(RDR_HALT), 32'h0);
    IN = 1'b1;
    drain("t4_resume_drain");

    // Space discarded, then CR
    exp_q.push_back(10'h100);
    push(5'h00);
    push(5'h02);
    drain("t5_space_cr_drain");

    // Control code table (0x06 is discarded)
    tbl_f = '{5'h01, 5'h03, 5'h05, 5'h06, 5'h07, 5'h1F};
    tbl_e = '{10'h010, 10'h100, 10'h020, 10'h000, 10'h080, 10'h20F};
    for (int i = 0; i < 6; i++) if (tbl_e[i] != 10'h000) exp_q.push_back(tbl_e[i]);
    for (int i = 0; i < 6; i++) push(tbl_f[i]);
    drain("t6_ctrl_table_drain");

    // Reset in second word of a 1-bit digit; queued frame must be flushed
    PREC1 = 1'b1;
    exp_q.push_back(10'h201);
    exp_q.push_back(10'h200);
    push(5'h1A);
    push(5'h17);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge CLOCK);
    check("t7_words_before_rst", 32'(exp_q.size()), 32'h0);
    @(negedge CLOCK);
    rst = 1'b1;
    #1;
    check("t7_rst_outputs", 32'(out_vec()), 32'h0);
    check("t7_rst_ready", 32'(host_ready), 32'h1);
    @(negedge CLOCK);
    rst = 1'b0;
    repeat (8) wait_t0();
    check("t7_no_more_words", 32'(exp_q.size()), 32'h0);
    check("t7_parity", 32'(PARITY_ERR), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
